// File: rtl/tambor_golpe_acondicionador.sv
// Piezo/button conditioner: 2-FF sync, debounced strike pulse with lockout, direction toggle.
// Optional strike counter on GOLPES enabled by defining TAMBOR_CONTEO_GOLPES_EN.
module tambor_golpe_acondicionador #(
  parameter int unsigned DEB_CYCLES  = 2_500_000,
  parameter int unsigned LOCK_CYCLES = 5_000_000,
  parameter int unsigned CNT_W       = 23
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       PIEZO,
  input  logic       UP_DOWN,
  output logic       GOLPE,
  output logic       GOLPE_DIR,
  output logic       PIEZO_ACTIVO,
  output logic       DIR,
  output logic       DIR_PULSO,
  output logic [7:0] GOLPES
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StQual    = 3'd1;
  localparam logic [2:0] StHit     = 3'd2;
  localparam logic [2:0] StLock    = 3'd3;
  localparam logic [2:0] StRelease = 3'd4;

  localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic             piezo_s1_q, piezo_s2_q;
  logic             btn_s1_q, btn_s2_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             golpe_q, golpe_d;
  logic             golpe_dir_q, golpe_dir_d;
  logic             activo_q, activo_d;
  logic             btn_q, btn_d;
  logic             btn_prev_q;
  logic [CNT_W-1:0] btn_cnt_q, btn_cnt_d;
  logic             btn_rise;
  logic             dir_q, dir_d;
  logic             dir_pulso_q, dir_pulso_d;

  // Strike FSM; GOLPE is registered on the QUAL->HIT edge so it coincides with HIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    golpe_d     = 1'b0;
    golpe_dir_d = golpe_dir_q;
    unique case (state_q)
      StIdle: begin
        if (piezo_s2_q) begin
          state_d = StQual;
          cnt_d   = '0;
        end
      end
      StQual: begin
        if (!piezo_s2_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DebLast) begin
          state_d     = StHit;
          cnt_d       = '0;
          golpe_d     = 1'b1;
          golpe_dir_d = dir_q;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StHit: begin
        state_d = StLock;
        cnt_d   = '0;
      end
      StLock: begin
        if (cnt_q == LockLast) begin
          state_d = StRelease;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRelease: begin
        if (piezo_s2_q) begin
          cnt_d = '0;
        end else if (cnt_q == DebLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    activo_d = (state_d == StHit) || (state_d == StLock) || (state_d == StRelease);
  end

  // Button debounce; DIR toggles one edge after the debounced level rises.
  always_comb begin
    btn_d     = btn_q;
    btn_cnt_d = btn_cnt_q;
    if (btn_s2_q == btn_q) begin
      btn_cnt_d = '0;
    end else if (btn_cnt_q == DebLast) begin
      btn_d     = btn_s2_q;
      btn_cnt_d = '0;
    end else begin
      btn_cnt_d = btn_cnt_q + CntOne;
    end
    btn_rise    = btn_q & ~btn_prev_q;
    dir_d       = dir_q ^ btn_rise;
    dir_pulso_d = btn_rise;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      piezo_s1_q  <= 1'b0;
      piezo_s2_q  <= 1'b0;
      btn_s1_q    <= 1'b0;
      btn_s2_q    <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      golpe_q     <= 1'b0;
      golpe_dir_q <= 1'b0;
      activo_q    <= 1'b0;
      btn_q       <= 1'b0;
      btn_prev_q  <= 1'b0;
      btn_cnt_q   <= '0;
      dir_q       <= 1'b0;
      dir_pulso_q <= 1'b0;
    end else begin
      piezo_s1_q  <= PIEZO;
      piezo_s2_q  <= piezo_s1_q;
      btn_s1_q    <= UP_DOWN;
      btn_s2_q    <= btn_s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      golpe_q     <= golpe_d;
      golpe_dir_q <= golpe_dir_d;
      activo_q    <= activo_d;
      btn_q       <= btn_d;
      btn_prev_q  <= btn_q;
      btn_cnt_q   <= btn_cnt_d;
      dir_q       <= dir_d;
      dir_pulso_q <= dir_pulso_d;
    end
  end

`ifdef TAMBOR_CONTEO_GOLPES_EN
  logic [7:0] golpes_q, golpes_d;

  // Counts on the same edge that raises GOLPE, saturating at 255.
  always_comb begin
    golpes_d = golpes_q;
    if (golpe_d && (golpes_q != 8'hFF)) begin
      golpes_d = golpes_q + 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      golpes_q <= 8'd0;
    end else begin
      golpes_q <= golpes_d;
    end
  end

  assign GOLPES = golpes_q;
`else
  assign GOLPES = 8'd0;
`endif

  assign GOLPE        = golpe_q;
  assign GOLPE_DIR    = golpe_dir_q;
  assign PIEZO_ACTIVO = activo_q;
  assign DIR          = dir_q;
  assign DIR_PULSO    = dir_pulso_q;

endmodule

// File: doc/tambor_golpe_acondicionador.md
Name: tambor_golpe_acondicionador

Overview:
- Input-conditioning stage that sits directly upstream of the drum counter/display/buzzer block.
- Turns the raw piezo sensor and the direction push-button into clean, synchronised, single-cycle events.
- Piezo output: one-cycle strike pulse with a post-hit lockout, so one physical hit never double-counts.
- Button output: debounced direction level plus a one-cycle toggle pulse.

Parameters:
DEB_CYCLES, 2_500_000, consecutive stable samples required to qualify a level (50 ms at 50 MHz); minimum 2
LOCK_CYCLES, 5_000_000, post-hit lockout length in clock cycles (100 ms); minimum 1
CNT_W, 23, width of the internal debounce/lockout counters; must hold max(DEB_CYCLES, LOCK_CYCLES)

Ports:
CLK  in  1  system clock, 50 MHz; single clock domain
RST  in  1  synchronous, active-high reset
PIEZO  in  1  raw piezo comparator output, asynchronous
UP_DOWN  in  1  raw direction push-button, asynchronous, active-high
GOLPE  out  1  one-cycle strike pulse
GOLPE_DIR  out  1  direction value captured with the current/last GOLPE
PIEZO_ACTIVO  out  1  high while the strike FSM is in HIT, LOCK or RELEASE
DIR  out  1  direction register: 0 = ascending, 1 = descending
DIR_PULSO  out  1  one-cycle pulse when DIR toggles
GOLPES  out  8  strike counter (see Optional Feature)

Behaviour:
- Reset is synchronous and active-high. The block has one clock.
- RST clears all state: synchronisers, counters, FSM (to IDLE), button level, DIR, GOLPE_DIR and GOLPES go to 0; GOLPE, DIR_PULSO and PIEZO_ACTIVO are 0.
- RST asserted mid-operation (any state, including LOCK) aborts on the next edge. No pulse is emitted on the reset edge or on the edge after it.
- Synchronisers: PIEZO and UP_DOWN each pass through 2 flip-flops (s1, s2). All logic below uses s2 only.
- Strike FSM states and transitions:
  - IDLE: if s2=1, go to QUAL and set cnt=0.
  - QUAL: if s2=0, go to IDLE (glitch rejected). Otherwise, if cnt==DEB_CYCLES-1 go to HIT; else cnt+1.
  - HIT: exactly 1 cycle with GOLPE=1, and GOLPE_DIR<=DIR. Then go to LOCK with cnt=0.
  - LOCK: ignore s2. When cnt==LOCK_CYCLES-1 go to RELEASE with cnt=0; else cnt+1.
  - RELEASE: if s2=1, cnt=0. If s2=0 and cnt==DEB_CYCLES-1, go to IDLE; else cnt+1. A new strike requires a qualified release first.
- All outputs are registered. Strike latency: counting edge 1 as the first edge that samples PIEZO=1, GOLPE is high for the cycle after edge DEB_CYCLES+3.
- A piezo held high forever produces exactly one GOLPE.
- Button debounce:
  - The debounced level btn (reset 0) changes only after DEB_CYCLES consecutive s2 samples that differ from btn.
  - Any sample equal to btn clears the count.
  - A rising edge of btn toggles DIR and pulses DIR_PULSO for 1 cycle, on the edge after btn rises.
  - A falling edge of btn has no effect.
- Simultaneous events: if GOLPE and a DIR toggle occur on the same edge, GOLPE_DIR takes the pre-toggle DIR. The new DIR is visible next cycle.
- Counters never wrap inside a state: each is reset on every state entry.

Optional Feature:
- Macro TAMBOR_CONTEO_GOLPES_EN.
- Defined: GOLPES is an 8-bit counter, incremented on each GOLPE, saturating at 255, cleared by RST.
- Undefined: GOLPES is tied to 8'd0 and no counter logic is synthesised.
- The port list is identical in both builds.

Test Plan (DEB_CYCLES=4, LOCK_CYCLES=8):
1. RST high 3 cycles, PIEZO=1 during reset -> all outputs 0; after release, GOLPE first high at edge 7 after release, once.
2. PIEZO pulses 1 for 3 cycles, 0, repeated 5 times -> GOLPE never asserted; FSM returns to IDLE each time.
3. PIEZO 1 for 20 cycles, then bounces 1/0 every 2 cycles for 10 cycles, then 0 for 10 cycles, then 1 for 10 -> exactly 2 GOLPE pulses; PIEZO_ACTIVO high from the first GOLPE until 4 stable-low cycles after the bounce.
4. UP_DOWN pressed 10 cycles, released 10, pressed again -> DIR 0→1→0; DIR_PULSO one cycle each press; a 2-cycle press glitch causes no toggle.
5. UP_DOWN and PIEZO raised on the same edge with DIR=0 -> GOLPE and DIR_PULSO on the same cycle; GOLPE_DIR=0, DIR=1 afterwards.
6. With TAMBOR_CONTEO_GOLPES_EN: 260 qualified strikes -> GOLPES=255 held. Without the macro -> GOLPES=0 throughout. RST asserted during LOCK -> IDLE; the next strike needs full qualification.
